// File: rtl/crc24_check_pkg.sv
// crc24_check_pkg: constants and state encoding shared by the BTLE CRC24
// transmit and receive blocks.
package crc24_check_pkg;

  // CRC length in bits
  localparam int CRC_LEN = 24;

  // Feedback tap mask of the BTLE CRC24 polynomial (bit k = tap into position k)
  localparam logic [23:0] CRC24_POLY_MASK = 24'h00065B;

  // LFSR preset used on advertising channels
  localparam logic [23:0] BTLE_ADV_INIT = 24'h555555;

  // Receive checker state encoding
  typedef logic [1:0] crc_state_t;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_FILL = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/crc24_core.sv
// crc24_core: single-step BTLE CRC24 LFSR update, shared by TX and RX.
// state[k] holds BTLE position k; position 23 is the oldest bit.
module crc24_core
  import crc24_check_pkg::*;
#(
  parameter int CRC_STATE_BIT_WIDTH = CRC_LEN
) (
  input  logic [CRC_STATE_BIT_WIDTH-1:0] state,
  input  logic                           in_bit,
  output logic [CRC_STATE_BIT_WIDTH-1:0] next_state
);

  logic fb;

  assign fb = in_bit ^ state[CRC_STATE_BIT_WIDTH-1];

  // Shift towards position 23; the mask has bit 0 set, so position 0 becomes fb
  assign next_state = {state[CRC_STATE_BIT_WIDTH-2:0], 1'b0}
                    ^ (CRC_STATE_BIT_WIDTH'(CRC24_POLY_MASK) & {CRC_STATE_BIT_WIDTH{fb}});

endmodule

// File: rtl/crc24_check.sv
// crc24_check: BTLE receive-side CRC24 checker.
// A 24-bit delay line holds back the most recent bits so that, when the
// last beat arrives, the delay line contains exactly the received CRC and
// everything that left it has been run through the LFSR and forwarded as
// PDU bits. Optional macro CRC24_CHECK_ERR_CNT_EN builds a saturating
// failed-frame counter on crc_err_count; without it the port is tied to 0.
module crc24_check
  import crc24_check_pkg::*;
#(
  parameter int CRC_STATE_BIT_WIDTH = CRC_LEN,
  parameter int FILL_CNT_WIDTH      = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CRC_STATE_BIT_WIDTH-1:0] crc_state_init_bit,
  input  logic                           crc_state_init_bit_load,
  input  logic                           rx_bit,
  input  logic                           rx_bit_valid,
  input  logic                           rx_bit_valid_last,
  output logic                           info_bit,
  output logic                           info_bit_valid,
  output logic                           info_bit_valid_last,
  output logic                           crc_ok,
  output logic                           crc_ok_valid,
  output logic                           short_frame,
  output logic [15:0]                    crc_err_count
);

  localparam logic [FILL_CNT_WIDTH-1:0] FILL_FULL = FILL_CNT_WIDTH'(CRC_STATE_BIT_WIDTH);

  crc_state_t                     state;
  logic [CRC_STATE_BIT_WIDTH-1:0] init_reg;
  logic [CRC_STATE_BIT_WIDTH-1:0] lfsr;
  logic [CRC_STATE_BIT_WIDTH-1:0] lfsr_next;
  logic [CRC_STATE_BIT_WIDTH-1:0] dly;
  logic [FILL_CNT_WIDTH-1:0]      fill_cnt;

  logic beat;
  logic last_beat;
  logic result_fire;
  logic frame_short;
  logic frame_ok;

  assign beat      = rx_bit_valid;
  assign last_beat = rx_bit_valid & rx_bit_valid_last;

  // In DONE the registers still hold the values from the last beat, even if
  // a new frame's first beat is being absorbed in the same cycle.
  assign frame_short = (fill_cnt < FILL_FULL);
  assign frame_ok    = !frame_short && (dly == lfsr);
  assign result_fire = (state == ST_DONE) && !crc_state_init_bit_load;

  crc24_core #(
    .CRC_STATE_BIT_WIDTH(CRC_STATE_BIT_WIDTH)
  ) u_core (
    .state     (lfsr),
    .in_bit    (dly[CRC_STATE_BIT_WIDTH-1]),
    .next_state(lfsr_next)
  );

  // Frame sequencing, delay line, LFSR and output strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= ST_IDLE;
      init_reg            <= '0;
      lfsr                <= '0;
      dly                 <= '0;
      fill_cnt            <= '0;
      info_bit            <= 1'b0;
      info_bit_valid      <= 1'b0;
      info_bit_valid_last <= 1'b0;
      crc_ok              <= 1'b0;
      crc_ok_valid        <= 1'b0;
      short_frame         <= 1'b0;
    end else begin
      info_bit_valid      <= 1'b0;
      info_bit_valid_last <= 1'b0;
      crc_ok_valid        <= 1'b0;
      short_frame         <= 1'b0;

      if (crc_state_init_bit_load) begin
        init_reg <= crc_state_init_bit;
      end

      if (beat) begin
        dly <= {dly[CRC_STATE_BIT_WIDTH-2:0], rx_bit};
      end

      if (result_fire) begin
        crc_ok       <= frame_ok;
        crc_ok_valid <= 1'b1;
        short_frame  <= frame_short;
      end

      if (crc_state_init_bit_load) begin
        // Abort whatever was in flight; a coincident beat opens a new frame
        if (beat) begin
          lfsr     <= crc_state_init_bit;
          fill_cnt <= FILL_CNT_WIDTH'(1);
          state    <= last_beat ? ST_DONE : ST_FILL;
        end else begin
          fill_cnt <= '0;
          state    <= ST_IDLE;
        end
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (beat) begin
              lfsr     <= init_reg;
              fill_cnt <= FILL_CNT_WIDTH'(1);
              state    <= last_beat ? ST_DONE : ST_FILL;
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_FILL: begin
            if (beat) begin
              fill_cnt <= fill_cnt + 1'b1;
              if (last_beat) begin
                state <= ST_DONE;
              end else if ((fill_cnt + 1'b1) == FILL_FULL) begin
                state <= ST_RUN;
              end
            end
          end
          ST_RUN: begin
            if (beat) begin
              lfsr                <= lfsr_next;
              info_bit            <= dly[CRC_STATE_BIT_WIDTH-1];
              info_bit_valid      <= 1'b1;
              info_bit_valid_last <= last_beat;
              if (last_beat) begin
                state <= ST_DONE;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef CRC24_CHECK_ERR_CNT_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  logic [15:0] err_cnt;

  // Count failed frames (short frames included), saturating at all ones
  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (result_fire && !frame_ok) begin
      err_cnt <= sat_inc16(err_cnt);
    end
  end

  assign crc_err_count = err_cnt;
`else
  assign crc_err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_crc24_check.sv
// tb_crc24_check: scoreboard bench for crc24_check. Frames are built from a
// bit-level CRC24 model; expected PDU bits and frame results are queued as
// stimulus is prepared and consumed as the DUT produces them.
module tb_crc24_check;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] crc_state_init_bit;
  logic        crc_state_init_bit_load;
  logic        rx_bit;
  logic        rx_bit_valid;
  logic        rx_bit_valid_last;
  logic        info_bit;
  logic        info_bit_valid;
  logic        info_bit_valid_last;
  logic        crc_ok;
  logic        crc_ok_valid;
  logic        short_frame;
  logic [15:0] crc_err_count;

  typedef struct packed {logic b; logic last;} beat_t;
  typedef struct packed {logic ok; logic short_f;} res_t;

  beat_t tx_q[$];
  beat_t exp_info_q[$];
  res_t  exp_res_q[$];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int exp_err   = 0;

  always #5 clk = ~clk;

  crc24_check dut (
    .clk                    (clk),
    .rst                    (rst),
    .crc_state_init_bit     (crc_state_init_bit),
    .crc_state_init_bit_load(crc_state_init_bit_load),
    .rx_bit                 (rx_bit),
    .rx_bit_valid           (rx_bit_valid),
    .rx_bit_valid_last      (rx_bit_valid_last),
    .info_bit               (info_bit),
    .info_bit_valid         (info_bit_valid),
    .info_bit_valid_last    (info_bit_valid_last),
    .crc_ok                 (crc_ok),
    .crc_ok_valid           (crc_ok_valid),
    .short_frame            (short_frame),
    .crc_err_count          (crc_err_count)
  );

  // Reference CRC24: bits[i] is the i-th transmitted PDU bit
  function automatic logic [23:0] crc_model(input logic [23:0] init, input logic [63:0] bits, input int n);
    logic [23:0] s;
    logic [23:0] ns;
    logic        fb;
    s = init;
    for (int i = 0; i < n; i++) begin
      fb    = bits[i] ^ s[23];
      ns[0] = fb;
      for (int k = 1; k < 24; k++) begin
        if (k == 1 || k == 3 || k == 4 || k == 6 || k == 9 || k == 10) ns[k] = s[k-1] ^ fb;
        else ns[k] = s[k-1];
      end
      s = ns;
    end
    return s;
  endfunction

  // Queue PDU bits (LSB first) plus CRC (position 23 first); flip_pos >= 0 corrupts one CRC bit
  task automatic make_frame(input logic [63:0] pdu, input int n, input logic [23:0] init, input int flip_pos);
    logic [23:0] crc;
    crc = crc_model(init, pdu, n);
    if (flip_pos >= 0) crc[flip_pos] = ~crc[flip_pos];
    for (int i = 0; i < n; i++) begin
      tx_q.push_back(beat_t'{b: pdu[i], last: 1'b0});
      exp_info_q.push_back(beat_t'{b: pdu[i], last: (i == n - 1)});
    end
    for (int k = 23; k >= 0; k--) begin
      tx_q.push_back(beat_t'{b: crc[k], last: (k == 0)});
    end
  endtask

  task automatic drive_beat(input logic b, input logic last, input logic load);
    rx_bit                  = b;
    rx_bit_valid            = 1'b1;
    rx_bit_valid_last       = last;
    crc_state_init_bit_load = load;
    @(posedge clk);
    #1;
    rx_bit_valid            = 1'b0;
    rx_bit_valid_last       = 1'b0;
    crc_state_init_bit_load = 1'b0;
  endtask

  // Send the queued beats, one every 'spacing' clocks; gaps carry a stray last flag
  task automatic send_all(input int spacing, input logic load_first);
    beat_t bt;
    bit    first;
    first = 1'b1;
    while (tx_q.size() > 0) begin
      bt = tx_q.pop_front();
      drive_beat(bt.b, bt.last, load_first && first);
      first = 1'b0;
      for (int g = 1; g < spacing; g++) begin
        rx_bit_valid_last = 1'b1;
        @(posedge clk);
        #1;
      end
      rx_bit_valid_last = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int c = 0; c < budget && (exp_info_q.size() > 0 || exp_res_q.size() > 0); c++) begin
      @(posedge clk);
      #1;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [23:0] v);
    crc_state_init_bit      = v;
    crc_state_init_bit_load = 1'b1;
    @(posedge clk);
    #1;
    crc_state_init_bit_load = 1'b0;
  endtask

  // Scoreboard monitor: sample outputs on the falling edge
  initial begin
    beat_t e;
    res_t  r;
    forever begin
      @(negedge clk);
      if (info_bit_valid) begin
        total_cnt++;
        if (exp_info_q.size() == 0) begin
          $display("FAIL info_unexpected: info_bit_valid=1 bit=%0b, required no info beat", info_bit);
        end else begin
          e = exp_info_q.pop_front();
          if ({info_bit, info_bit_valid_last} !== {e.b, e.last})
            $display("FAIL info_bit: got bit=%0b last=%0b, required bit=%0b last=%0b",
                     info_bit, info_bit_valid_last, e.b, e.last);
          else pass_cnt++;
        end
      end
      if (crc_ok_valid) begin
        total_cnt++;
        if (exp_res_q.size() == 0) begin
          $display("FAIL result_unexpected: crc_ok_valid=1 crc_ok=%0b, required no result", crc_ok);
        end else begin
          r = exp_res_q.pop_front();
          if ({crc_ok, short_frame} !== {r.ok, r.short_f})
            $display("FAIL frame_result: got crc_ok=%0b short=%0b, required crc_ok=%0b short=%0b",
                     crc_ok, short_frame, r.ok, r.short_f);
          else pass_cnt++;
        end
      end
      if (short_frame && !crc_ok_valid) begin
        total_cnt++;
        $display("FAIL short_alone: short_frame=1 with crc_ok_valid=0, required coincident");
      end
    end
  end

  task automatic test_reset();
    rst                     = 1'b1;
    crc_state_init_bit      = 24'h0;
    crc_state_init_bit_load = 1'b0;
    rx_bit                  = 1'b0;
    rx_bit_valid            = 1'b0;
    rx_bit_valid_last       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if ({info_bit, info_bit_valid, info_bit_valid_last, crc_ok, crc_ok_valid, short_frame} !== 6'b0)
      $display("FAIL reset_outputs: got %06b, required 000000",
               {info_bit, info_bit_valid, info_bit_valid_last, crc_ok, crc_ok_valid, short_frame});
    else pass_cnt++;
    total_cnt++;
    if (crc_err_count !== 16'h0) $display("FAIL reset_err_count: got %h, required 0000", crc_err_count);
    else pass_cnt++;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_empty_pdu();
    pulse_load(24'h555555);
    make_frame(64'h0, 0, 24'h555555, -1);
    exp_res_q.push_back(res_t'{ok: 1'b1, short_f: 1'b0});
    send_all(1, 1'b0);
    wait_drain(50);
    total_cnt++;
    if (exp_info_q.size() != 0 || exp_res_q.size() != 0)
      $display("FAIL empty_pdu_drain: pending info=%0d res=%0d, required 0/0", exp_info_q.size(), exp_res_q.size());
    else pass_cnt++;
    exp_info_q.delete();
    exp_res_q.delete();
  endtask

  task automatic test_full_frame();
    make_frame(64'h2540, 16, 24'h555555, -1);
    exp_res_q.push_back(res_t'{ok: 1'b1, short_f: 1'b0});
    send_all(16, 1'b0);
    wait_drain(100);
    total_cnt++;
    if (exp_info_q.size() != 0 || exp_res_q.size() != 0)
      $display("FAIL full_frame_drain: pending info=%0d res=%0d, required 0/0", exp_info_q.size(), exp_res_q.size());
    else pass_cnt++;
    exp_info_q.delete();
    exp_res_q.delete();
    repeat (10) @(posedge clk);
    #1;
    total_cnt++;
    if (crc_ok !== 1'b1) $display("FAIL crc_ok_hold: got %0b, required 1", crc_ok);
    else pass_cnt++;
  endtask

  task automatic test_crc_error();
    make_frame(64'h2540, 16, 24'h555555, 5);
    exp_res_q.push_back(res_t'{ok: 1'b0, short_f: 1'b0});
    exp_err++;
    send_all(16, 1'b0);
    wait_drain(100);
    total_cnt++;
    if (exp_info_q.size() != 0 || exp_res_q.size() != 0)
      $display("FAIL crc_error_drain: pending info=%0d res=%0d, required 0/0", exp_info_q.size(), exp_res_q.size());
    else pass_cnt++;
    exp_info_q.delete();
    exp_res_q.delete();
    total_cnt++;
`ifdef CRC24_CHECK_ERR_CNT_EN
    if (crc_err_count !== 16'(exp_err)) $display("FAIL err_count_bad_crc: got %0d, required %0d", crc_err_count, exp_err);
`else
    if (crc_err_count !== 16'h0) $display("FAIL err_count_bad_crc: got %0d, required 0", crc_err_count);
`endif
    else pass_cnt++;
  endtask

  task automatic test_short_frame();
    for (int i = 0; i < 10; i++) tx_q.push_back(beat_t'{b: 1'($urandom_range(0, 1)), last: (i == 9)});
    exp_res_q.push_back(res_t'{ok: 1'b0, short_f: 1'b1});
    exp_err++;
    send_all(1, 1'b0);
    wait_drain(50);
    total_cnt++;
    if (exp_info_q.size() != 0 || exp_res_q.size() != 0)
      $display("FAIL short_frame_drain: pending info=%0d res=%0d, required 0/0", exp_info_q.size(), exp_res_q.size());
    else pass_cnt++;
    exp_info_q.delete();
    exp_res_q.delete();
    total_cnt++;
`ifdef CRC24_CHECK_ERR_CNT_EN
    if (crc_err_count !== 16'(exp_err)) $display("FAIL err_count_short: got %0d, required %0d", crc_err_count, exp_err);
`else
    if (crc_err_count !== 16'h0) $display("FAIL err_count_short: got %0d, required 0", crc_err_count);
`endif
    else pass_cnt++;
  endtask

  // Seven beats of a frame, then a new init loaded together with the first beat of a fresh frame
  task automatic test_abort_load();
    for (int i = 0; i < 7; i++) tx_q.push_back(beat_t'{b: 1'($urandom_range(0, 1)), last: 1'b0});
    send_all(1, 1'b0);
    crc_state_init_bit = 24'h123456;
    make_frame(64'hA5C3, 16, 24'h123456, -1);
    exp_res_q.push_back(res_t'{ok: 1'b1, short_f: 1'b0});
    send_all(1, 1'b1);
    wait_drain(60);
    total_cnt++;
    if (exp_info_q.size() != 0 || exp_res_q.size() != 0)
      $display("FAIL abort_load_drain: pending info=%0d res=%0d, required 0/0", exp_info_q.size(), exp_res_q.size());
    else pass_cnt++;
    exp_info_q.delete();
    exp_res_q.delete();
  endtask

  // Contiguous beats: the second frame's first beat lands in the DONE cycle
  task automatic test_back_to_back();
    make_frame(64'h3A, 8, 24'h123456, -1);
    make_frame(64'hC5, 8, 24'h123456, -1);
    exp_res_q.push_back(res_t'{ok: 1'b1, short_f: 1'b0});
    exp_res_q.push_back(res_t'{ok: 1'b1, short_f: 1'b0});
    send_all(1, 1'b0);
    wait_drain(60);
    total_cnt++;
    if (exp_info_q.size() != 0 || exp_res_q.size() != 0)
      $display("FAIL back_to_back_drain: pending info=%0d res=%0d, required 0/0", exp_info_q.size(), exp_res_q.size());
    else pass_cnt++;
    exp_info_q.delete();
    exp_res_q.delete();
  endtask

  // Reset mid-frame, then a frame that relies on the reset init value of 0
  task automatic test_rst_mid_frame();
    for (int i = 0; i < 10; i++) tx_q.push_back(beat_t'{b: 1'($urandom_range(0, 1)), last: 1'b0});
    send_all(1, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({info_bit, info_bit_valid, info_bit_valid_last, crc_ok, crc_ok_valid, short_frame} !== 6'b0 ||
        crc_err_count !== 16'h0)
      $display("FAIL rst_mid_frame_outputs: got %06b cnt=%0d, required 000000 cnt=0",
               {info_bit, info_bit_valid, info_bit_valid_last, crc_ok, crc_ok_valid, short_frame}, crc_err_count);
    else pass_cnt++;
    rst     = 1'b0;
    exp_err = 0;
    @(posedge clk);
    #1;
    make_frame(64'h96, 8, 24'h000000, -1);
    exp_res_q.push_back(res_t'{ok: 1'b1, short_f: 1'b0});
    send_all(1, 1'b0);
    wait_drain(60);
    total_cnt++;
    if (exp_info_q.size() != 0 || exp_res_q.size() != 0)
      $display("FAIL rst_mid_frame_drain: pending info=%0d res=%0d, required 0/0", exp_info_q.size(), exp_res_q.size());
    else pass_cnt++;
    exp_info_q.delete();
    exp_res_q.delete();
  endtask

  initial begin
    test_reset();
    test_empty_pdu();
    test_full_frame();
    test_crc_error();
    test_short_frame();
    test_abort_load();
    test_back_to_back();
    test_rst_mid_frame();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/crc24_check.md
Name: crc24_check

Overview:
- Receive-side counterpart of crc24 in the BTLE RX chain.
- Consumes the dewhitened serial bitstream (PDU bits followed by 24 CRC bits), runs the BTLE CRC24 LFSR over the PDU bits, and compares the result with the received CRC.
- Forwards PDU bits downstream with the CRC stripped, and emits a per-frame pass/fail pulse.
- Uses a 24-bit delay line, so no length field is needed: the frame end is marked by rx_bit_valid_last.

Parameters:
- CRC_STATE_BIT_WIDTH, 24, LFSR and delay-line width. Fixed at 24 for BTLE.
- FILL_CNT_WIDTH, 5, width of the delay-line fill counter. Must hold the value 24.

Ports:
- clk  in  1  system clock (16 MHz).
- rst  in  1  synchronous, active-high reset.
- crc_state_init_bit  in  24  LFSR init value (0x555555 for advertising).
- crc_state_init_bit_load  in  1  one-cycle pulse; captures the init value and aborts any frame in progress.
- rx_bit  in  1  received bit.
- rx_bit_valid  in  1  beat strobe.
- rx_bit_valid_last  in  1  qualifies the final CRC bit; only meaningful together with rx_bit_valid.
- info_bit  out  1  PDU bit with CRC stripped.
- info_bit_valid  out  1  info_bit strobe.
- info_bit_valid_last  out  1  marks the last PDU bit.
- crc_ok  out  1  1 = received CRC matches the computed CRC. Held until the next frame result.
- crc_ok_valid  out  1  one-cycle result pulse.
- short_frame  out  1  one-cycle pulse, coincident with crc_ok_valid, when the frame had fewer than 24 bits.
- crc_err_count  out  16  see Optional Feature.

Behaviour:
- Reset values:
  - All outputs 0.
  - init_reg, lfsr, dly and fill_cnt all 0.
  - State IDLE.
- LFSR: bit-order identical to crc24.
  - state[k] = BTLE position k.
  - fb = in ^ state[23].
  - new state[0] = fb.
  - new state[k] = state[k-1] ^ fb for k in {1,3,4,6,9,10}.
  - new state[k] = state[k-1] otherwise.
  - Init value loads state directly (bit k -> position k).
  - CRC is transmitted position 23 first.
- Delay line dly[23:0]: dly[0] is the newest bit. Each beat shifts rx_bit into dly[0].
- States:
  - IDLE: waits for first beat. The first beat sets lfsr = init_reg, fill_cnt = 1, and moves to FILL.
  - FILL: beats increment fill_cnt. On reaching 24, move to RUN.
  - RUN: each beat shifts dly. The outgoing bit dly[23] is fed into the LFSR and presented on info_bit/info_bit_valid in the next cycle (latency 1 cycle from the beat).
  - DONE: one cycle. Registered compare crc_ok = (dly == lfsr), with crc_ok_valid = 1. Then go to IDLE.
- Last beat (rx_bit_valid && rx_bit_valid_last):
  - The final dly shift and LFSR update happen in the same cycle.
  - If in RUN, info_bit_valid_last accompanies the final PDU bit (1 cycle after the beat).
  - Next state is DONE, so crc_ok_valid asserts 2 cycles after the last beat.
- Exactly 24 bits (empty PDU):
  - No info_bit_valid.
  - Compare is against init_reg.
- Fewer than 24 bits at last:
  - crc_ok = 0, short_frame = 1 with crc_ok_valid.
  - No info output.
- crc_state_init_bit_load:
  - Captures init_reg and forces IDLE with fill_cnt = 0.
  - A frame in progress is discarded with no crc_ok_valid.
  - If a beat coincides with the load, the beat is taken as the first beat of a new frame using the new init value.
- Back-to-back frames: a beat arriving during DONE is the first beat of the next frame. The compare uses the snapshot taken at the last beat.
- rx_bit_valid_last without rx_bit_valid is ignored.
- rst mid-frame: everything returns to reset values; no pulses are emitted.

Optional Feature:
- Macro: CRC24_CHECK_ERR_CNT_EN.
- Enabled: crc_err_count increments, saturating at 0xFFFF, on each crc_ok_valid with crc_ok = 0 (short frames included). It is cleared only by rst.
- Disabled: crc_err_count is tied to 0 and no counter logic is built.

Decomposition:
- Shared package holds:
  - CRC24 polynomial tap mask 0x00065B.
  - BTLE advertising init constant 0x555555.
  - CRC length 24.
  - State encoding IDLE/FILL/RUN/DONE.
- One sub-module: crc24_core, the single-step LFSR update shared with the TX crc24. crc24_check instantiates it.

Test Plan:
- Empty PDU: load 0x555555, then 24 beats 0,1,0,1,…,1 (position 23 first) -> crc_ok_valid with crc_ok = 1; no info_bit_valid.
- Full frame: crc24 output for a 16-bit PDU 0x2540 at init 0x555555, fed at 1 Mb/s (every 16 clocks) -> info bits equal the 16 PDU bits; info_bit_valid_last on the 16th; crc_ok = 1.
- Same frame with CRC bit 5 flipped -> crc_ok = 0. With the macro enabled, crc_err_count = 1.
- 10-bit frame with last on bit 10 -> crc_ok_valid, crc_ok = 0, short_frame = 1.
- Load pulse at bit 8 of a frame, then a fresh valid frame -> no result for the aborted frame; the fresh frame gives crc_ok = 1.
- Two valid frames back-to-back, with the second frame's first beat arriving during DONE -> two crc_ok_valid pulses, both with crc_ok = 1.
